spi_target: RTL and testbench

//   SPI responder (mode 0: CPOL=0, CPHA=0, MSB first, CS active-low) that terminates the MCU SPI bus
//   (PA4..PA7) inside the CPLD instead of forwarding it to the PMOD connector.

---
 rtl/spi_target_if.sv | 26 ++
 rtl/spi_target.sv | 160 ++++++++++++++++
 tb/tb_spi_target.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/spi_target_if.sv
// rtl/spi_target_if.sv - SPI pins plus byte-side rx/tx handshake of the SPI target.
interface spi_target_if #(
    parameter int WIDTH = 8
);
    logic             spi_cs;
    logic             spi_sck;
    logic             spi_pico;
    logic             spi_poci;
    logic             spi_poci_oe;
    logic [WIDTH-1:0] tx_data;
    logic             tx_req;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_first;
    logic             busy;

    modport slave (
        input  spi_cs, spi_sck, spi_pico, tx_data,
        output spi_poci, spi_poci_oe, tx_req, rx_data, rx_valid, rx_first, busy
    );

    modport master (
        output spi_cs, spi_sck, spi_pico, tx_data,
        input  spi_poci, spi_poci_oe, tx_req, rx_data, rx_valid, rx_first, busy
    );
endinterface

// File: rtl/spi_target.sv
// rtl/spi_target.sv - Mode-0 SPI responder oversampling the MCU pins on the system clock.
module spi_target #(
    parameter int   WIDTH       = 8,
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_POCI   = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    spi_target_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, pico_sync_q;
    logic                   cs_prev_q, sck_prev_q;

    state_t           state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_first_q, rx_first_d;
    logic             tx_req_q, tx_req_d;
    logic             first_q, first_d;
    logic             reload_q, reload_d;
    logic             poci_q, poci_d;
    logic             oe_q, oe_d;

    logic cs_s, sck_s, pico_s;
    logic cs_fall, cs_rise, sck_rise, sck_fall;
    logic [WIDTH-1:0] rx_next;

    // cs synchronizer resets high so reset release never looks like a select
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync_q   <= '1;
            sck_sync_q  <= '0;
            pico_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sck_prev_q  <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.spi_sck};
            pico_sync_q <= {pico_sync_q[SYNC_STAGES-2:0], bus.spi_pico};
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign pico_s   = pico_sync_q[SYNC_STAGES-1];
    assign cs_fall  = cs_prev_q & ~cs_s;
    assign cs_rise  = ~cs_prev_q & cs_s;
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign rx_next  = {rx_sh_q[WIDTH-2:0], pico_s};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_sh_d    = rx_sh_q;
        tx_sh_d    = tx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_first_d = 1'b0;
        tx_req_d   = 1'b0;
        first_d    = first_q;
        reload_d   = reload_q;
        oe_d       = oe_q;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = ACTIVE;
                    tx_sh_d   = bus.tx_data;
                    tx_req_d  = 1'b1;
                    bit_cnt_d = '0;
                    rx_sh_d   = '0;
                    first_d   = 1'b1;
                    reload_d  = 1'b0;
                    oe_d      = 1'b1;
                end
            end
            ACTIVE: begin
                // deselect overrides any sck edge seen in the same cycle
                if (cs_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    rx_sh_d   = '0;
                    reload_d  = 1'b0;
                    oe_d      = 1'b0;
                end else if (sck_rise) begin
                    rx_sh_d = rx_next;
                    if (bit_cnt_q == CW'(WIDTH - 1)) begin
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
                        rx_first_d = first_q;
                        first_d    = 1'b0;
                        bit_cnt_d  = '0;
                        reload_d   = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end else if (sck_fall) begin
                    if (reload_q) begin
                        tx_sh_d  = bus.tx_data;
                        tx_req_d = 1'b1;
                        reload_d = 1'b0;
                    end else begin
                        tx_sh_d = tx_sh_q << 1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        poci_d = (state_q == ACTIVE && !cs_rise) ? tx_sh_q[WIDTH-1] : IDLE_POCI;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_sh_q    <= '0;
            tx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            tx_req_q   <= 1'b0;
            first_q    <= 1'b0;
            reload_q   <= 1'b0;
            poci_q     <= IDLE_POCI;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_sh_q    <= rx_sh_d;
            tx_sh_q    <= tx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_first_q <= rx_first_d;
            tx_req_q   <= tx_req_d;
            first_q    <= first_d;
            reload_q   <= reload_d;
            poci_q     <= poci_d;
            oe_q       <= oe_d;
        end
    end

    assign bus.spi_poci    = poci_q;
    assign bus.spi_poci_oe = oe_q;
    assign bus.tx_req      = tx_req_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.rx_first    = rx_first_q;
    assign bus.busy        = (state_q == ACTIVE);
endmodule

// File: tb/tb_spi_target.sv
// tb/tb_spi_target.sv - Scoreboard bench for spi_target driving mode-0 frames at clk/8.
module tb_spi_target;
    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_target_if #(.WIDTH(8)) bus ();

    spi_target #(.WIDTH(8), .SYNC_STAGES(2), .IDLE_POCI(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    logic [7:0] pico_list[$];
    logic [7:0] tx_list[$];
    int         frame_id = 0;
    int         rx_cnt   = 0;
    int         tx_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // monitor + tx responder: word k of a frame returns tx_list[k]
    initial begin
        logic [7:0] prev_rx;
        logic [8:0] e;
        int seen_frame;
        int idx;
        prev_rx    = 8'h00;
        seen_frame = 0;
        idx        = 0;
        bus.tx_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rx = 8'h00;
            end else begin
                if (bus.rx_valid) begin
                    rx_cnt++;
                    if (exp_q.size() == 0) begin
                        check("rx_unexpected", 32'(bus.rx_data), 32'hffff_ffff);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_data", 32'(bus.rx_data), 32'(e[7:0]));
                        check("rx_first", 32'(bus.rx_first), 32'(e[8]));
                    end
                end else if (bus.rx_data !== prev_rx) begin
                    check("rx_data_hold", 32'(bus.rx_data), 32'(prev_rx));
                end
                prev_rx = bus.rx_data;
                if (bus.tx_req) tx_cnt++;
            end
            if (frame_id != seen_frame) begin
                seen_frame = frame_id;
                idx = 0;
            end else if (bus.tx_req && !rst) begin
                idx++;
            end
            bus.tx_data = (idx < tx_list.size()) ? tx_list[idx] : 8'h00;
        end
    end

    // MCU side; partial_bits>0 aborts the last word after that many bits (by cs or by rst)
    task automatic frame(input int nwords, input int partial_bits, input bit abort_rst);
        logic [7:0] rd;
        int nb;
        int rx0;
        int tx0;
        rx0 = rx_cnt;
        tx0 = tx_cnt;
        frame_id++;
        repeat (2) @(negedge clk);
        bus.spi_cs = 1'b0;
        repeat (8) @(negedge clk);
        for (int w = 0; w < nwords; w++) begin
            nb = (partial_bits > 0 && w == nwords - 1) ? partial_bits : 8;
            if (nb == 8) exp_q.push_back({(w == 0), pico_list[w]});
            rd = 8'h00;
            for (int b = 0; b < nb; b++) begin
                bus.spi_pico = pico_list[w][7-b];
                repeat (4) @(negedge clk);
                rd = {rd[6:0], bus.spi_poci};
                if (b == 0) begin
                    check("oe_active", 32'(bus.spi_poci_oe), 32'd1);
                    check("busy_active", 32'(bus.busy), 32'd1);
                end
                bus.spi_sck = 1'b1;
                repeat (4) @(negedge clk);
                bus.spi_sck = 1'b0;
                if (partial_bits == 0 && w == nwords - 1 && b == 7) bus.spi_cs = 1'b1;
            end
            if (nb == 8) check("mcu_read", 32'(rd), 32'(tx_list[w]));
        end
        if (partial_bits > 0) begin
            repeat (4) @(negedge clk);
            if (abort_rst) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_poci", 32'(bus.spi_poci), 32'd1);
                check("rst_oe", 32'(bus.spi_poci_oe), 32'd0);
                check("rst_tx_req", 32'(bus.tx_req), 32'd0);
                check("rst_rx_data", 32'(bus.rx_data), 32'd0);
                check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
                check("rst_rx_first", 32'(bus.rx_first), 32'd0);
                check("rst_busy", 32'(bus.busy), 32'd0);
                bus.spi_cs = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b0;
            end else begin
                bus.spi_cs = 1'b1;
            end
        end
        repeat (8) @(negedge clk);
        check("busy_idle", 32'(bus.busy), 32'd0);
        check("oe_idle", 32'(bus.spi_poci_oe), 32'd0);
        check("rx_count", 32'(rx_cnt - rx0), 32'((partial_bits > 0) ? nwords - 1 : nwords));
        check("tx_req_count", 32'(tx_cnt - tx0), 32'((partial_bits > 0) ? nwords : nwords));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rx0;
        int tx0;
        bus.spi_cs   = 1'b1;
        bus.spi_sck  = 1'b0;
        bus.spi_pico = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_poci", 32'(bus.spi_poci), 32'd1);
        check("reset_oe", 32'(bus.spi_poci_oe), 32'd0);
        check("reset_rx_data", 32'(bus.rx_data), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        pico_list = '{8'hA5};
        tx_list   = '{8'h3C};
        frame(1, 0, 1'b0);

        pico_list = '{8'h01, 8'h02, 8'h03};
        tx_list   = '{8'h3C, 8'h11, 8'h22};
        frame(3, 0, 1'b0);

        pico_list = '{8'hFF};
        tx_list   = '{8'h96};
        frame(1, 5, 1'b0);
        pico_list = '{8'h5A};
        tx_list   = '{8'h69};
        frame(1, 0, 1'b0);

        rx0 = rx_cnt;
        tx0 = tx_cnt;
        for (int t = 0; t < 16; t++) begin
            bus.spi_pico = 1'($urandom_range(0, 1));
            bus.spi_sck  = ~bus.spi_sck;
            repeat (4) @(negedge clk);
            check("idle_oe", 32'(bus.spi_poci_oe), 32'd0);
            check("idle_poci", 32'(bus.spi_poci), 32'd1);
        end
        check("idle_rx_count", 32'(rx_cnt - rx0), 32'd0);
        check("idle_tx_count", 32'(tx_cnt - tx0), 32'd0);

        pico_list = '{8'hE7};
        tx_list   = '{8'h81};
        frame(1, 4, 1'b1);
        pico_list = '{8'hC3};
        tx_list   = '{8'h7E};
        frame(1, 0, 1'b0);

        pico_list.delete();
        tx_list.delete();
        for (int i = 0; i < 256; i++) begin
            pico_list.push_back(8'($urandom));
            tx_list.push_back(8'($urandom));
        end
        frame(256, 0, 1'b0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
